// File: rtl/bus_pkg.sv
// Shared definitions for the narrow bus bridge.
//   size_e          : transfer size as presented by the core (3 is folded into word)
//   state_e         : bridge FSM states
//   CMD_*           : bit positions inside the command beat
//   data_beat_count : number of data beats needed for a given transfer size
package bus_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        COMMAND,
        ADDRESS,
        DATA,
        RESPOND
    } state_e;

    // Command beat layout: {0..., size[1:0], write}
    localparam int CMD_WRITE_BIT = 0;
    localparam int CMD_SIZE_LSB  = 1;
    localparam int CMD_SIZE_MSB  = 2;

    // max(1, ceil((8 << size) / pin_width)), capped at data_width / pin_width
    function automatic int data_beat_count(input size_e size, input int pin_width,
                                           input int data_width);
        int bits;
        int beats;
        bits  = 8 << size;
        beats = (bits + pin_width - 1) / pin_width;
        if (beats < 1) begin
            beats = 1;
        end
        if (beats > data_width / pin_width) begin
            beats = data_width / pin_width;
        end
        return beats;
    endfunction

endpackage

// File: rtl/narrow_bus_bridge_if.sv
// Signal bundle between the core load/store port, the bridge and the pin bus.
//   slave  : the bridge's view (takes requests, answers responses, drives pins)
//   master : the environment's view (core plus the external pin-side device)
interface narrow_bus_bridge_if #(
    parameter int CPU_ADDRESS_WIDTH = 16,
    parameter int CPU_DATA_WIDTH    = 32,
    parameter int PIN_WIDTH         = 8
);
    // Core request side
    logic                         request_valid;
    logic                         request_ready;
    logic                         request_write;
    logic [1:0]                   request_size;
    logic [CPU_ADDRESS_WIDTH-1:0] request_address;
    logic [CPU_DATA_WIDTH-1:0]    request_write_data;
    // Core response side
    logic                         response_valid;
    logic [CPU_DATA_WIDTH-1:0]    response_read_data;
    logic                         response_error;
    // Pin bus
    logic [PIN_WIDTH-1:0]         pin_out;
    logic                         pin_oe;
    logic [PIN_WIDTH-1:0]         pin_in;
    logic                         pin_valid;
    logic                         pin_ready;
    logic                         pin_last;

    modport slave (
        input  request_valid, request_write, request_size, request_address, request_write_data,
        output request_ready,
        output response_valid, response_read_data, response_error,
        output pin_out, pin_oe, pin_valid, pin_last,
        input  pin_in, pin_ready
    );

    modport master (
        output request_valid, request_write, request_size, request_address, request_write_data,
        input  request_ready,
        input  response_valid, response_read_data, response_error,
        input  pin_out, pin_oe, pin_valid, pin_last,
        output pin_in, pin_ready
    );
endinterface

// File: rtl/beat_shifter.sv
// Lane shift register used for both directions of the pin bus.
//   load_i/load_data_i : parallel load of the whole word (has priority over shift)
//   shift_i            : move every lane down by PIN_WIDTH; serial_i enters the top lane
//   word_o             : current contents; the bottom lane is the outgoing beat
// WIDTH must be a multiple of PIN_WIDTH.
module beat_shifter #(
    parameter int WIDTH     = 32,
    parameter int PIN_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 load_i,
    input  logic [WIDTH-1:0]     load_data_i,
    input  logic                 shift_i,
    input  logic [PIN_WIDTH-1:0] serial_i,
    output logic [WIDTH-1:0]     word_o
);
    localparam int LANES = WIDTH / PIN_WIDTH;

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;
    logic [WIDTH-1:0] shifted;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            if (gi == LANES - 1) begin : g_top
                assign shifted[gi*PIN_WIDTH +: PIN_WIDTH] = serial_i;
            end else begin : g_lower
                assign shifted[gi*PIN_WIDTH +: PIN_WIDTH] = word_q[(gi+1)*PIN_WIDTH +: PIN_WIDTH];
            end
        end
    endgenerate

    always_comb begin
        word_d = word_q;
        if (load_i) begin
            word_d = load_data_i;
        end else if (shift_i) begin
            word_d = shifted;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o = word_q;
endmodule

// File: rtl/narrow_bus_bridge.sv
// Serialises core load/store requests onto a narrow pin bus:
// one command beat, ADDRESS_BEATS address beats (LSB first), then the data beats
// (write data LSB first, or read data collected LSB first from pin_in).
//   clock, reset_n : single clock, asynchronous active-low reset
//   bus (slave)    : request/response handshake towards the core and the pin bus
// A beat that stalls for TIMEOUT_CYCLES consecutive cycles aborts the transfer with
// response_error set (TIMEOUT_CYCLES = 0 disables the abort).
// request_ready is also raised during the RESPOND cycle so a waiting request is taken
// at the edge that ends it and back-to-back transfers have no idle gap.
module narrow_bus_bridge #(
    parameter int CPU_ADDRESS_WIDTH = 16,
    parameter int CPU_DATA_WIDTH    = 32,
    parameter int PIN_WIDTH         = 8,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input logic                clock,
    input logic                reset_n,
    narrow_bus_bridge_if.slave bus
);
    import bus_pkg::*;

    localparam int ADDRESS_BEATS  = (CPU_ADDRESS_WIDTH + PIN_WIDTH - 1) / PIN_WIDTH;
    localparam int DATA_BEATS_MAX = CPU_DATA_WIDTH / PIN_WIDTH;
    localparam int MAX_BEATS      = (ADDRESS_BEATS > DATA_BEATS_MAX) ? ADDRESS_BEATS : DATA_BEATS_MAX;
    localparam int BEAT_W         = $clog2(MAX_BEATS + 1);
    localparam int SHIFT_W        = (ADDRESS_BEATS * PIN_WIDTH > CPU_DATA_WIDTH)
                                    ? ADDRESS_BEATS * PIN_WIDTH : CPU_DATA_WIDTH;
    // A disabled timeout still needs a 1-bit counter to keep the declarations legal.
    localparam int STALL_W        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [STALL_W-1:0] STALL_LIMIT       = STALL_W'(TIMEOUT_CYCLES);
    localparam logic [BEAT_W-1:0]  LAST_ADDRESS_BEAT = BEAT_W'(ADDRESS_BEATS - 1);

    state_e                    state_q, state_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [STALL_W-1:0]        stall_q, stall_d;
    logic                      error_q, error_d;
    logic                      write_q, write_d;
    size_e                     size_q, size_d;
    logic [CPU_DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                      shift_load;
    logic [SHIFT_W-1:0]        shift_load_data;
    logic                      shift_en;
    logic [PIN_WIDTH-1:0]      shift_serial;
    logic [SHIFT_W-1:0]        shift_word;

    logic [BEAT_W-1:0]         data_beats;
    logic                      beat_done;
    logic                      stalled;
    logic                      accept;
    logic [STALL_W-1:0]        stall_inc;
    logic [SHIFT_W-1:0]        rd_aligned;
    logic [PIN_WIDTH-1:0]      command_beat;

    // One shifter serves the whole transfer: address is loaded on accept, then either
    // the write data or zero is loaded when the last address beat completes. On reads
    // pin_in enters at the top, so the received beats end up in the top lanes.
    beat_shifter #(
        .WIDTH     (SHIFT_W),
        .PIN_WIDTH (PIN_WIDTH)
    ) u_shifter (
        .clock       (clock),
        .reset_n     (reset_n),
        .load_i      (shift_load),
        .load_data_i (shift_load_data),
        .shift_i     (shift_en),
        .serial_i    (shift_serial),
        .word_o      (shift_word)
    );

    assign data_beats = BEAT_W'(data_beat_count(size_q, PIN_WIDTH, CPU_DATA_WIDTH));
    assign stall_inc  = stall_q + STALL_W'(1);
    // Bring the received beats down to bit 0; everything above them is the zeros
    // loaded before the data phase.
    assign rd_aligned = shift_word >> (SHIFT_W - int'(data_beats) * PIN_WIDTH);

    always_comb begin
        command_beat                                = '0;
        command_beat[CMD_WRITE_BIT]                 = write_q;
        command_beat[CMD_SIZE_MSB:CMD_SIZE_LSB]     = size_q;
    end

    always_comb begin
        state_d         = state_q;
        beat_d          = beat_q;
        stall_d         = stall_q;
        error_d         = error_q;
        write_d         = write_q;
        size_d          = size_q;
        wdata_d         = wdata_q;
        shift_load      = 1'b0;
        shift_load_data = '0;
        shift_en        = 1'b0;
        shift_serial    = '0;

        bus.request_ready      = (state_q == IDLE) || (state_q == RESPOND);
        bus.response_valid     = 1'b0;
        bus.response_error     = 1'b0;
        bus.response_read_data = '0;
        bus.pin_out            = '0;
        bus.pin_oe             = 1'b0;
        bus.pin_valid          = (state_q == COMMAND) || (state_q == ADDRESS) || (state_q == DATA);
        bus.pin_last           = 1'b0;

        beat_done = bus.pin_valid && bus.pin_ready;
        stalled   = bus.pin_valid && !bus.pin_ready;
        accept    = bus.request_ready && bus.request_valid;

        if (beat_done) begin
            stall_d = '0;
        end else if (stalled && (TIMEOUT_CYCLES != 0)) begin
            stall_d = stall_inc;
        end

        unique case (state_q)
            IDLE: begin
            end
            COMMAND: begin
                bus.pin_oe  = 1'b1;
                bus.pin_out = command_beat;
                if (beat_done) begin
                    state_d = ADDRESS;
                    beat_d  = '0;
                end
            end
            ADDRESS: begin
                bus.pin_oe  = 1'b1;
                bus.pin_out = shift_word[PIN_WIDTH-1:0];
                if (beat_done) begin
                    if (beat_q == LAST_ADDRESS_BEAT) begin
                        state_d         = DATA;
                        beat_d          = '0;
                        shift_load      = 1'b1;
                        shift_load_data = write_q ? SHIFT_W'(wdata_q) : '0;
                    end else begin
                        beat_d   = beat_q + BEAT_W'(1);
                        shift_en = 1'b1;
                    end
                end
            end
            DATA: begin
                bus.pin_oe   = write_q;
                bus.pin_out  = write_q ? shift_word[PIN_WIDTH-1:0] : '0;
                bus.pin_last = (beat_q == data_beats - BEAT_W'(1));
                if (beat_done) begin
                    shift_en     = 1'b1;
                    shift_serial = write_q ? '0 : bus.pin_in;
                    if (bus.pin_last) begin
                        state_d = RESPOND;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            RESPOND: begin
                bus.response_valid = 1'b1;
                bus.response_error = error_q;
                if (!error_q && !write_q) begin
                    bus.response_read_data = rd_aligned[CPU_DATA_WIDTH-1:0];
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Timeout only fires on a stalled beat, so it never coincides with a shift.
        if ((TIMEOUT_CYCLES != 0) && stalled && (stall_inc == STALL_LIMIT)) begin
            state_d = RESPOND;
            error_d = 1'b1;
            beat_d  = '0;
            stall_d = '0;
        end

        if (accept) begin
            state_d         = COMMAND;
            beat_d          = '0;
            stall_d         = '0;
            error_d         = 1'b0;
            write_d         = bus.request_write;
            size_d          = (bus.request_size == 2'd3) ? SIZE_WORD : size_e'(bus.request_size);
            wdata_d         = bus.request_write_data;
            shift_load      = 1'b1;
            shift_load_data = SHIFT_W'(bus.request_address);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            stall_q <= '0;
            error_q <= 1'b0;
            write_q <= 1'b0;
            size_q  <= SIZE_BYTE;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            stall_q <= stall_d;
            error_q <= error_d;
            write_q <= write_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
        end
    end
endmodule
